// File: rtl/branch_pkg.sv
// Shared encodings for the branch unit: PCSrc selects, MIPS opcode/funct values,
// table FSM states and the 2-bit saturating counter step.
package branch_pkg;

    typedef enum logic [2:0] {
        PCSRC_SEQ     = 3'd0,
        PCSRC_BRANCH  = 3'd1,
        PCSRC_JUMP    = 3'd2,
        PCSRC_JR      = 3'd3,
        PCSRC_RECOVER = 3'd4
    } pcsrc_e;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } tbl_state_e;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_REGIMM  = 6'b000001;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] OP_BLEZ    = 6'b000110;
    localparam logic [5:0] OP_BGTZ    = 6'b000111;
    localparam logic [5:0] FUNCT_JR   = 6'b001000;

    localparam logic [1:0] CTR_INIT = 2'b01;
    localparam logic [1:0] CTR_MAX  = 2'b11;

    function automatic logic [1:0] ctr_step(input logic [1:0] ctr, input logic up);
        if (up)
            return (ctr == 2'b11) ? ctr : ctr + 2'b01;
        else
            return (ctr == 2'b00) ? ctr : ctr - 2'b01;
    endfunction

endpackage

// File: rtl/bht_btb_table.sv
// Direct-mapped BHT/BTB storage: INIT sweep FSM, asynchronous lookup and
// training-read ports, one write port shared by counter and entry updates.
module bht_btb_table
    import branch_pkg::*;
#(
    parameter int PC_W    = 32,
    parameter int DEPTH   = 64,
    parameter int INDEX_W = $clog2(DEPTH),
    parameter int TAG_W   = PC_W - INDEX_W - 2
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               Invalidate,
    output logic               busy,
    input  logic [INDEX_W-1:0] lk_idx,
    output logic               lk_valid,
    output logic [1:0]         lk_ctr,
    output logic [TAG_W-1:0]   lk_tag,
    output logic [PC_W-1:0]    lk_target,
    input  logic [INDEX_W-1:0] tr_idx,
    output logic [1:0]         tr_ctr,
    input  logic               wr_ctr_en,
    input  logic [1:0]         wr_ctr,
    input  logic               wr_entry_en,
    input  logic               wr_valid,
    input  logic [TAG_W-1:0]   wr_tag,
    input  logic [PC_W-1:0]    wr_target
);

    tbl_state_e         state_reg, state_next;
    logic [INDEX_W-1:0] ptr_reg, ptr_next;

    logic               valid_mem  [DEPTH];
    logic [1:0]         ctr_mem    [DEPTH];
    logic [TAG_W-1:0]   tag_mem    [DEPTH];
    logic [PC_W-1:0]    target_mem [DEPTH];

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_reg <= ST_INIT;
            ptr_reg   <= '0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        case (state_reg)
            ST_INIT: begin
                ptr_next = ptr_reg + INDEX_W'(1);
                if (ptr_reg == INDEX_W'(DEPTH - 1)) begin
                    state_next = ST_RUN;
                    ptr_next   = '0;
                end
            end
            ST_RUN: begin
                if (Invalidate) begin
                    state_next = ST_INIT;
                    ptr_next   = '0;
                end
            end
            default: state_next = ST_INIT;
        endcase
    end

    assign busy = (state_reg == ST_INIT);

    // Training in the invalidating cycle is dropped; the sweep owns the write port in INIT.
    always_ff @(posedge Clk) begin
        if (state_reg == ST_INIT) begin
            valid_mem[ptr_reg] <= 1'b0;
            ctr_mem[ptr_reg]   <= CTR_INIT;
        end else if (!Invalidate) begin
            if (wr_ctr_en)
                ctr_mem[tr_idx] <= wr_ctr;
            if (wr_entry_en) begin
                valid_mem[tr_idx]  <= wr_valid;
                tag_mem[tr_idx]    <= wr_tag;
                target_mem[tr_idx] <= wr_target;
            end
        end
    end

    assign lk_valid  = valid_mem[lk_idx];
    assign lk_ctr    = ctr_mem[lk_idx];
    assign lk_tag    = tag_mem[lk_idx];
    assign lk_target = target_mem[lk_idx];
    assign tr_ctr    = ctr_mem[tr_idx];

endmodule

// File: rtl/branch_resolve_predict.sv
// Branch unit top: fetch-side prediction lookup plus ID-stage resolve/train.
// Define BRANCH_STATS_EN to build the saturating BranchCount/MispredCount counters.
module branch_resolve_predict
    import branch_pkg::*;
#(
    parameter int PC_W   = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              Invalidate,
    input  logic [PC_W-1:0]   FetchPC,
    output logic              PredTaken,
    output logic [PC_W-1:0]   PredTarget,
    input  logic              ResValid,
    input  logic [PC_W-1:0]   ResPC,
    input  logic [31:0]       Instruction,
    input  logic [DATA_W-1:0] ReadReg1,
    input  logic [DATA_W-1:0] ReadReg2,
    input  logic              ResPredTaken,
    input  logic [PC_W-1:0]   ResPredTarget,
    output logic [2:0]        PCSrc,
    output logic              Flush,
    output logic              RegWrite2BC,
    output logic              Busy,
    output logic [31:0]       BranchCount,
    output logic [31:0]       MispredCount
);

    localparam int INDEX_W = $clog2(DEPTH);
    localparam int TAG_W   = PC_W - INDEX_W - 2;

    logic               busy, run;
    logic               lk_valid;
    logic [1:0]         lk_ctr, tr_ctr, wr_ctr;
    logic [TAG_W-1:0]   lk_tag;
    logic [PC_W-1:0]    lk_target, wr_target;
    logic               wr_ctr_en, wr_entry_en, wr_valid;
    logic               unused_fetch_lsb;

    bht_btb_table #(
        .PC_W(PC_W), .DEPTH(DEPTH), .INDEX_W(INDEX_W), .TAG_W(TAG_W)
    ) u_table (
        .Clk(Clk), .Reset_n(Reset_n), .Invalidate(Invalidate), .busy(busy),
        .lk_idx(FetchPC[INDEX_W+1:2]), .lk_valid(lk_valid), .lk_ctr(lk_ctr),
        .lk_tag(lk_tag), .lk_target(lk_target),
        .tr_idx(ResPC[INDEX_W+1:2]), .tr_ctr(tr_ctr),
        .wr_ctr_en(wr_ctr_en), .wr_ctr(wr_ctr), .wr_entry_en(wr_entry_en),
        .wr_valid(wr_valid), .wr_tag(ResPC[PC_W-1:INDEX_W+2]), .wr_target(wr_target)
    );

    assign run              = ~busy;
    assign Busy             = busy;
    assign unused_fetch_lsb = ^FetchPC[1:0];

    assign PredTaken  = run & lk_valid & (lk_tag == FetchPC[PC_W-1:INDEX_W+2]) & lk_ctr[1];
    assign PredTarget = PredTaken ? lk_target : '0;

    logic [5:0]       opcode;
    logic [PC_W-1:0]  seq_pc, br_target, j_target;
    logic [PC_W+17:0] br_off;
    logic [PC_W+27:0] j_field, j_mask;
    logic             r1_neg, r1_zero;
    logic             is_cond, is_jump, is_jr, cond_taken;
    logic             hit_br, hit_j;
    pcsrc_e           pcsrc;

    assign opcode  = Instruction[31:26];
    assign seq_pc  = ResPC + PC_W'(4);
    assign br_off  = {{PC_W{Instruction[15]}}, Instruction[15:0], 2'b00};
    assign br_target = seq_pc + br_off[PC_W-1:0];
    // Widened so the region splice stays legal for any PC_W.
    assign j_field = {{PC_W{1'b0}}, Instruction[25:0], 2'b00};
    assign j_mask  = {{PC_W{1'b0}}, {28{1'b1}}};
    assign j_target = (seq_pc & ~j_mask[PC_W-1:0]) | j_field[PC_W-1:0];
    assign r1_neg  = ReadReg1[DATA_W-1];
    assign r1_zero = (ReadReg1 == '0);
    assign hit_br  = ResPredTaken & (ResPredTarget == br_target);
    assign hit_j   = ResPredTaken & (ResPredTarget == j_target);

    always_comb begin
        is_cond    = 1'b0;
        is_jump    = 1'b0;
        is_jr      = 1'b0;
        cond_taken = 1'b0;
        case (opcode)
            OP_REGIMM: begin
                is_cond    = 1'b1;
                cond_taken = Instruction[16] ? ~r1_neg : r1_neg;
            end
            OP_BEQ:  begin is_cond = 1'b1; cond_taken = (ReadReg1 == ReadReg2); end
            OP_BNE:  begin is_cond = 1'b1; cond_taken = (ReadReg1 != ReadReg2); end
            OP_BGTZ: begin is_cond = 1'b1; cond_taken = ~r1_neg & ~r1_zero; end
            OP_BLEZ: begin is_cond = 1'b1; cond_taken = r1_neg | r1_zero; end
            OP_J, OP_JAL: is_jump = 1'b1;
            OP_SPECIAL:   is_jr = (Instruction[5:0] == FUNCT_JR);
            default: ;
        endcase
    end

    always_comb begin
        pcsrc       = PCSRC_SEQ;
        wr_ctr_en   = 1'b0;
        wr_ctr      = tr_ctr;
        wr_entry_en = 1'b0;
        wr_valid    = 1'b0;
        wr_target   = br_target;
        if (ResValid && run) begin
            if (is_cond) begin
                wr_ctr_en = 1'b1;
                wr_ctr    = ctr_step(tr_ctr, cond_taken);
                if (cond_taken) begin
                    wr_entry_en = 1'b1;
                    wr_valid    = 1'b1;
                    pcsrc       = hit_br ? PCSRC_SEQ : PCSRC_BRANCH;
                end else if (ResPredTaken) begin
                    pcsrc = PCSRC_RECOVER;
                end
            end else if (is_jump) begin
                wr_ctr_en   = 1'b1;
                wr_ctr      = CTR_MAX;
                wr_entry_en = 1'b1;
                wr_valid    = 1'b1;
                wr_target   = j_target;
                pcsrc       = hit_j ? PCSRC_SEQ : PCSRC_JUMP;
            end else if (is_jr) begin
                pcsrc = PCSRC_JR;
            end else if (ResPredTaken) begin
                // Predicted-taken non-branch: an aliasing entry, evict it.
                wr_entry_en = 1'b1;
                pcsrc       = PCSRC_RECOVER;
            end
        end
    end

    assign PCSrc       = pcsrc;
    assign Flush       = (pcsrc != PCSRC_SEQ);
    assign RegWrite2BC = ResValid & run & (opcode == OP_JAL);

`ifdef BRANCH_STATS_EN
    logic [31:0] branch_count_reg, mispred_count_reg;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            branch_count_reg  <= '0;
            mispred_count_reg <= '0;
        end else if (ResValid && run) begin
            if ((is_cond || is_jump || is_jr) && branch_count_reg != '1)
                branch_count_reg <= branch_count_reg + 32'd1;
            if (Flush && mispred_count_reg != '1)
                mispred_count_reg <= mispred_count_reg + 32'd1;
        end
    end

    assign BranchCount  = branch_count_reg;
    assign MispredCount = mispred_count_reg;
`else
    assign BranchCount  = '0;
    assign MispredCount = '0;
`endif

endmodule
